// File: rtl/vram_pkg.sv
// Shared types and geometry for the VRAM responder: FSM states and beat/alignment constants.
package vram_pkg;
  localparam int DEF_VLEN    = 512;
  localparam int DEF_BEAT_W  = 64;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_SRAM_AW = 16;

  localparam int BEATS      = DEF_VLEN / DEF_BEAT_W;
  localparam int BEAT_SHIFT = $clog2(DEF_BEAT_W / 8);
  localparam int ALIGN_BITS = $clog2(DEF_VLEN / 8);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RDLAST,
    RESP
  } state_t;
endpackage

// File: rtl/v_vram_beat_sel.sv
// Picks beat idx (BEAT_W bits) out of a full vector and its write mask.
module v_vram_beat_sel #(
  parameter int VLEN   = 512,
  parameter int BEAT_W = 64,
  parameter int IDX_W  = 3
) (
  input  logic [VLEN-1:0]   vec,
  input  logic [VLEN-1:0]   mask,
  input  logic [IDX_W-1:0]  idx,
  output logic [BEAT_W-1:0] beat,
  output logic [BEAT_W-1:0] beat_mask
);
  localparam int N = VLEN / BEAT_W;

  logic [BEAT_W-1:0] data_arr [N];
  logic [BEAT_W-1:0] mask_arr [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slice
      assign data_arr[gi] = vec[gi*BEAT_W +: BEAT_W];
      assign mask_arr[gi] = mask[gi*BEAT_W +: BEAT_W];
    end
  endgenerate

  assign beat      = data_arr[idx];
  assign beat_mask = mask_arr[idx];
endmodule

// File: rtl/v_vram_responder.sv
// Full-vector ready/valid VRAM responder serving each request as sequential beats
// on a narrow single-port synchronous SRAM.
module v_vram_responder
  import vram_pkg::*;
#(
  parameter int VLEN    = DEF_VLEN,
  parameter int BEAT_W  = DEF_BEAT_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int SRAM_AW = DEF_SRAM_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [VLEN-1:0]    req_wdata,
  input  logic [VLEN-1:0]    req_wmask,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [VLEN-1:0]    rsp_rdata,
  output logic               rsp_err,
  output logic               sram_en,
  output logic               sram_we,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [BEAT_W-1:0]  sram_wdata,
  output logic [BEAT_W-1:0]  sram_wmask,
  input  logic [BEAT_W-1:0]  sram_rdata
);
  localparam int N_BEATS = VLEN / BEAT_W;
  localparam int SHIFT   = $clog2(BEAT_W / 8);
  localparam int ABITS   = $clog2(VLEN / 8);
  localparam int CW      = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_BEATS - 1);

  state_t              state_reg, state_next;
  logic [CW-1:0]       cnt_reg, cnt_next;
  logic [SRAM_AW-1:0]  base_reg, base_next;
  logic [VLEN-1:0]     wdata_reg, wdata_next;
  logic [VLEN-1:0]     wmask_reg, wmask_next;
  logic [VLEN-1:0]     rdata_reg, rdata_next;
  logic                err_reg, err_next;
  // Holds req_ready low until the first edge after reset release.
  logic                up_reg;

  logic [ADDR_W-1:0]   addr_sh;
  logic [BEAT_W-1:0]   beat_data, beat_mask;
  logic                beat_en;

  assign addr_sh = req_addr >> SHIFT;

  v_vram_beat_sel #(
    .VLEN   (VLEN),
    .BEAT_W (BEAT_W),
    .IDX_W  (CW)
  ) u_beat_sel (
    .vec       (wdata_reg),
    .mask      (wmask_reg),
    .idx       (cnt_reg),
    .beat      (beat_data),
    .beat_mask (beat_mask)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      base_reg  <= '0;
      wdata_reg <= '0;
      wmask_reg <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
      up_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      base_reg  <= base_next;
      wdata_reg <= wdata_next;
      wmask_reg <= wmask_next;
      rdata_reg <= rdata_next;
      err_reg   <= err_next;
      up_reg    <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    base_next  = base_reg;
    wdata_next = wdata_reg;
    wmask_next = wmask_reg;
    rdata_next = rdata_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid && up_reg) begin
          cnt_next   = '0;
          base_next  = addr_sh[SRAM_AW-1:0];
          wdata_next = req_wdata;
          wmask_next = req_wmask;
          rdata_next = '0;
          err_next   = 1'b0;
          if (req_addr[ABITS-1:0] != '0) begin
            err_next   = 1'b1;
            state_next = RESP;
          end else begin
            state_next = req_we ? WR : RD;
          end
        end
      end
      WR: begin
        if (cnt_reg == LAST) state_next = RESP;
        else                 cnt_next   = cnt_reg + CW'(1);
      end
      RD: begin
        // Data for the beat issued last cycle is on sram_rdata now.
        if (cnt_reg != '0)
          rdata_next[(int'(cnt_reg) - 1)*BEAT_W +: BEAT_W] = sram_rdata;
        if (cnt_reg == LAST) state_next = RDLAST;
        else                 cnt_next   = cnt_reg + CW'(1);
      end
      RDLAST: begin
        rdata_next[int'(LAST)*BEAT_W +: BEAT_W] = sram_rdata;
        state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
          rdata_next = '0;
          err_next   = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign beat_en    = (state_reg == WR) ? (|beat_mask) : (state_reg == RD);
  assign req_ready  = (state_reg == IDLE) && up_reg;
  assign rsp_valid  = (state_reg == RESP);
  assign rsp_rdata  = rsp_valid ? rdata_reg : '0;
  assign rsp_err    = rsp_valid & err_reg;
  assign sram_en    = beat_en;
  assign sram_we    = (state_reg == WR);
  assign sram_addr  = beat_en ? (base_reg + SRAM_AW'(cnt_reg)) : '0;
  assign sram_wdata = (beat_en && sram_we) ? beat_data : '0;
  assign sram_wmask = (beat_en && sram_we) ? beat_mask : '0;
endmodule
